// File: rtl/uart_tx_unit.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a four-state serialiser.
// The line and frame_done are registered one cycle behind the FSM, so both stay glitch-free and aligned.
module uart_tx_unit #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       frame_done,
    output logic [4:0] fifo_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;

    logic [CW-1:0] baud;
    logic          bit_end;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tx_next;
    logic          done_next;

    // Byte buffer

    assign tx_ready      = (fifo_count != DEPTH);
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (fifo_count != '0);

    always_ff @(posedge clk_50M) begin
        if (push && !reset) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Serialiser FSM

    assign bit_end = (baud == BAUD_LAST);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = fifo_nonempty ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next   = 1'b1;
        done_next = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                pop = fifo_nonempty;
            end
            START: begin
                tx_next = 1'b0;
            end
            DATA: begin
                tx_next = shreg[0];
            end
            STOP: begin
                done_next = bit_end;
                pop       = bit_end && fifo_nonempty;
            end
            default: begin
                tx_next = 1'b1;
            end
        endcase
    end

    // Bit timing and shift register
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if ((state == IDLE) || (state_next != state) || bit_end) begin
                baud <= '0;
            end else begin
                baud <= baud + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (pop) begin
                shreg <= mem[rd_ptr];
            end else if ((state == DATA) && bit_end) begin
                shreg <= {1'b0, shreg[7:1]};
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_next;
            frame_done <= done_next;
        end
    end

    // frame_done covers the final stop-bit cycle that the line still carries after the FSM is back in IDLE
    assign tx_busy = (state != IDLE) || frame_done || fifo_nonempty;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboard bench for uart_tx_unit: accepted bytes are queued, and a line monitor decodes each
// frame cycle by cycle and compares it with the queue head. A default-parameter instance checks bit timing.
module tb_uart_tx_unit;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 10 * CPB;
    localparam int unsigned SLOW  = 434;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       line;
    logic       tx_busy;
    logic       frame_done;
    logic [4:0] fifo_count;

    logic [7:0] data2;
    logic       valid2;
    logic       ready2;
    logic       line2;
    logic       busy2;
    logic       done2;
    logic [4:0] count2;

    int unsigned checks = 0;
    int unsigned fails = 0;
    int unsigned cycle = 0;
    int unsigned bytes_sent = 0;
    int unsigned lost = 0;
    int unsigned decoded = 0;

    logic [7:0]  sb[$];
    int unsigned starts[$];
    logic [7:0]  burst[4] = '{8'h46, 8'h49, 8'h4D, 8'h2D};

    uart_tx_unit #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk_50M    (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (line),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count)
    );

    uart_tx_unit #(.CLKS_PER_BIT(SLOW), .FIFO_DEPTH(8)) dut_slow (
        .clk_50M    (clk),
        .reset      (reset),
        .tx_data    (data2),
        .tx_valid   (valid2),
        .tx_ready   (ready2),
        .tx         (line2),
        .tx_busy    (busy2),
        .frame_done (done2),
        .fifo_count (count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned sget(input int unsigned i);
        return (i < starts.size()) ? starts[i] : 0;
    endfunction

    task automatic send(input logic [7:0] b, input bit hold,
                        output int unsigned waited, output int unsigned acc);
        waited   = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && waited < 500) begin
            tick();
            waited++;
        end
        if (!tx_ready) check("ready_timeout", tx_ready, 1'b1);
        tick();
        acc = cycle;
        sb.push_back(b);
        bytes_sent++;
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic wait_starts(input int unsigned n);
        int unsigned k = 0;
        while (starts.size() < n && k < 200) begin
            tick();
            k++;
        end
        check("frame_start_seen", starts.size() >= n, 1'b1);
    endtask

    task automatic wait_idle;
        int unsigned k = 0;
        while ((tx_busy || sb.size() != 0) && k < 3000) begin
            tick();
            k++;
        end
        check("idle_reached", {tx_busy, sb.size() != 0}, 2'b00);
    endtask

    // Line monitor: one frame is FRAME cycles sampled on the falling edge
    initial begin : monitor
        logic [9:0]  bits;
        logic [7:0]  e;
        logic [39:0] got_line;
        logic [39:0] exp_line;
        logic [39:0] got_done;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (!reset && line === 1'b0) begin
                check("frame_expected", sb.size() != 0, 1'b1);
                e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                bits = {1'b1, e, 1'b0};
                starts.push_back(cycle);
                aborted = 1'b0;
                got_line = '0;
                got_done = '0;
                exp_line = '0;
                for (int unsigned c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    got_line[c] = line;
                    got_done[c] = frame_done;
                    exp_line[c] = bits[c / CPB];
                end
                if (!aborted) begin
                    check("frame_line", got_line, exp_line);
                    check("frame_done_pos", got_done, 64'h1 << (FRAME - 1));
                    decoded++;
                end
            end
        end
    end

    initial begin : main
        int unsigned w;
        int unsigned acc;
        int unsigned s;
        int unsigned n;
        int unsigned n_done;
        int unsigned n_low;
        int unsigned st;
        int unsigned t0;
        logic        cur;

        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        valid2   = 1'b0;
        data2    = 8'h00;
        repeat (3) tick();
        check("reset_outputs", {line, tx_busy, frame_done, tx_ready}, 4'b1001);
        check("reset_count", fifo_count, 0);
        check("reset_slow_line", line2, 1'b1);
        reset    = 1'b0;
        tx_valid = 1'b0;
        repeat (2) tick();
        check("reset_push_ignored", {fifo_count, tx_busy}, 6'd0);

        // single 'F' from idle
        starts.delete();
        send(8'h46, 1'b0, w, acc);
        wait_starts(1);
        check("latency", sget(0) - acc, 2);
        wait_idle();

        // "FIM-" burst with valid held
        starts.delete();
        for (int unsigned i = 0; i < 4; i++) send(burst[i], i < 3, w, acc);
        n = 0;
        while (sb.size() != 0 && n < 400) begin tick(); n++; end
        n = 0;
        while (!frame_done && n < 100) begin tick(); n++; end
        check("busy_at_last_done", {frame_done, tx_busy}, 2'b11);
        tick();
        check("busy_after_done", {frame_done, tx_busy}, 2'b00);
        check("burst_frames", starts.size(), 4);
        for (int unsigned i = 1; i < 4; i++) check("burst_gap", sget(i) - sget(i - 1), FRAME);

        // push during the last stop cycle with an empty FIFO restarts via IDLE
        starts.delete();
        send(8'h3C, 1'b0, w, acc);
        wait_starts(1);
        s = sget(0);
        while (cycle < s + FRAME - 2) tick();
        check("stop_last_empty", fifo_count, 0);
        send(8'hC3, 1'b0, w, acc);
        check("push_at_stop_end", acc, s + FRAME - 1);
        wait_starts(2);
        check("restart_via_idle", sget(1) - s, FRAME + 1);
        wait_idle();

        // push coinciding with pop at count 3, then 20 bytes across the pointer wrap
        starts.delete();
        for (int unsigned i = 0; i < 4; i++) send(8'h10 + 8'(i), i < 3, w, acc);
        wait_starts(1);
        s = sget(0);
        while (cycle < s + FRAME - 2) tick();
        check("count_before_coincide", fifo_count, 3);
        send(8'h77, 1'b0, w, acc);
        check("coincide_edge", acc, s + FRAME - 1);
        check("count_push_pop", fifo_count, 3);
        check("coincide_done", frame_done, 1'b1);
        for (int unsigned i = 0; i < 20; i++) send(8'($urandom), i < 19, w, acc);
        wait_idle();

        // fill to eight with a frame in flight, ninth byte must wait for the pop
        starts.delete();
        send(8'hA1, 1'b0, w, acc);
        wait_starts(1);
        s = sget(0);
        for (int unsigned i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b1, w, acc);
        check("full_count", fifo_count, 8);
        check("full_ready", tx_ready, 1'b0);
        send(8'h5A, 1'b0, w, acc);
        check("ninth_held", w > 0, 1'b1);
        check("ninth_accept_edge", acc, s + FRAME);
        check("ninth_count", fifo_count, 8);
        wait_idle();

        // reset in data bit 3 with three bytes queued
        starts.delete();
        for (int unsigned i = 0; i < 4; i++) send(8'hC0 + 8'(i), i < 3, w, acc);
        wait_starts(1);
        s = sget(0);
        while (cycle < s + 4 * CPB + 1) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_line", line, 1'b1);
        check("abort_count", fifo_count, 0);
        check("abort_flags", {tx_busy, tx_ready}, 2'b01);
        lost += sb.size();
        sb.delete();
        n_done = 0;
        n_low  = 0;
        for (int unsigned i = 0; i < 60; i++) begin
            if (frame_done) n_done++;
            if (!line) n_low++;
            tick();
        end
        check("no_done_after_reset", n_done, 0);
        check("line_idle_after_reset", n_low, 0);
        send(8'hA5, 1'b0, w, acc);
        wait_idle();

        // default timing on the slow instance, byte 0x55
        data2  = 8'h55;
        valid2 = 1'b1;
        tick();
        valid2 = 1'b0;
        data2  = 8'h00;
        n = 0;
        while (line2 && n < 10) begin tick(); n++; end
        check("slow_start", line2, 1'b0);
        t0  = cycle;
        cur = 1'b0;
        for (int unsigned k = 0; k < 9; k++) begin
            st = cycle;
            n  = 0;
            while (line2 === cur && n < 1000) begin tick(); n++; end
            check("slow_bit_len", cycle - st, SLOW);
            cur = ~cur;
        end
        st = cycle;
        n  = 0;
        while (!done2 && n < 1000) begin tick(); n++; end
        check("slow_stop_len", cycle - st + 1, SLOW);
        check("slow_frame_len", cycle - t0 + 1, 10 * SLOW);

        check("sb_drained", sb.size(), 0);
        check("frames_decoded", decoded, bytes_sent - lost - 1);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_unit.md
UART_TX_UNIT -- requirements
Module: uart_tx_unit

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clk_50M cycles per bit (115200 baud at 50 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving byte buffer depth; only powers of two from 2 to 16 are legal.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk_50M  in  1  system clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: tx_data  in  8  byte to transmit (ASCII message character).
REQ-007 Port: tx_valid  in  1  tx_data is valid this cycle.
REQ-008 Port: tx_ready  out  1  high when the FIFO can accept a byte.
REQ-009 Port: tx  out  1  serial line, 8N1, LSB first, idle high.
REQ-010 Port: tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 Port: frame_done  out  1  one-cycle pulse at the end of each stop bit.
REQ-012 Port: fifo_count  out  5  number of bytes held in the FIFO, 0..FIFO_DEPTH.

Function
REQ-013 A byte SHALL be accepted on a rising edge only when tx_valid and tx_ready are both high; accepted bytes are transmitted in order and exactly once.
REQ-014 tx_ready SHALL equal (fifo_count != FIFO_DEPTH); it is combinational from registered state only, with no path from tx_valid.
REQ-015 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-016 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-017 IDLE: tx=1; when fifo_count>0, pop the head byte into the shift register and go to START.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA: drive shift register bit 0 for CLKS_PER_BIT cycles per bit; shift right 8 times using a 3-bit bit index, then go to STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; assert frame_done on the last cycle; then pop and go to START if fifo_count>0, otherwise go to IDLE.
REQ-021 Back-to-back frames SHALL have zero idle cycles between a stop bit and the next start bit.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1 and be cleared on every state change; one frame lasts exactly 10*CLKS_PER_BIT cycles.
REQ-023 Latency: with the FSM in IDLE and the FIFO empty, tx SHALL fall on the 2nd rising edge after the accepting edge.
REQ-024 A push while in STOP's last cycle with the FIFO empty SHALL NOT start the next frame in that cycle; it starts one cycle later via IDLE.
REQ-025 tx_data SHALL be sampled only at acceptance; later changes to tx_data SHALL NOT affect queued or in-flight bytes.
REQ-026 tx SHALL be driven from a register and be glitch-free.

Reset
REQ-027 While reset is high: tx=1, tx_busy=0, frame_done=0, fifo_count=0, tx_ready=1, FSM=IDLE, pointers and counters=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame, force tx=1 on the next edge, and discard all FIFO contents.
REQ-029 A byte presented in a cycle where reset is high SHALL NOT be accepted.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8 unless stated)
REQ-030 Single byte 0x46 ('F') from idle -> tx low on the 2nd edge after acceptance, then 0,1,1,0,0,0,1,0, then stop 1, each bit 4 cycles; frame_done pulses once at cycle 40 of the frame.
REQ-031 Burst "FIM-" (0x46, 0x49, 0x4D, 0x2D) with tx_valid held high -> 4 contiguous 40-cycle frames with no gap, decoded in order; tx_busy falls 1 cycle after the last frame_done.
REQ-032 Push 9 bytes with no pops -> tx_ready low once fifo_count=8; the 9th byte is held until the first pop and is accepted on the cycle tx_ready returns high.
REQ-033 Reset pulsed at bit 3 of a frame with 3 bytes queued -> tx=1, fifo_count=0, no frame_done afterwards; the next pushed byte transmits correctly.
REQ-034 Push coinciding with a pop at fifo_count=3 -> fifo_count stays 3; pointer wrap across 20 queued bytes preserves order.
REQ-035 Default parameters, byte 0x55 -> each bit lasts exactly 434 cycles and the frame lasts 4340 cycles.
